// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus of instr_encoder.
// Signal suffixes are relative to the encoder: slave = encoder, master = producer/memory side.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [2:0]        op_i;
    logic [3:0]        alu_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [20:0]       imm_i;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic              imem_ready_i;

    modport slave (
        input  req_valid_i, op_i, alu_i, rd_i, rs1_i, rs2_i, imm_i, imem_ready_i,
        output req_ready_o, imem_we_o, imem_addr_o, imem_data_o
    );

    modport master (
        output req_valid_i, op_i, alu_i, rd_i, rs1_i, rs2_i, imm_i, imem_ready_i,
        input  req_ready_o, imem_we_o, imem_addr_o, imem_data_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic RV32I requests into instruction words, buffers them in a
// 2-entry FIFO and writes them to instruction memory at consecutive addresses.
module instr_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_encoder_if.slave bus,
    output logic           err_o,
    output logic [15:0]    word_cnt_o
);

    typedef enum logic [2:0] {
        OP_R    = 3'd0,
        OP_ADDI = 3'd1,
        OP_LW   = 3'd2,
        OP_SW   = 3'd3,
        OP_BEQ  = 3'd4,
        OP_JAL  = 3'd5,
        OP_JALR = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    op_e               op;
    logic [31:0]       enc_word;
    logic              enc_bad;
    logic              imm12_ok;
    logic              imm13_ok;
    logic              accept;
    logic              push;
    logic              pop;

    logic [31:0]       fifo_q [2];
    logic [31:0]       fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic              err_q, err_d;

    assign op = op_e'(bus.op_i);

    // Immediate fits when every bit above the field's sign bit equals it.
    assign imm12_ok = (&bus.imm_i[20:11]) | ~(|bus.imm_i[20:11]);
    assign imm13_ok = (&bus.imm_i[20:12]) | ~(|bus.imm_i[20:12]);

    always_comb begin
        enc_word = '0;
        enc_bad  = 1'b0;
        case (op)
            OP_R: begin
                enc_word = {(bus.alu_i[3] ? 7'b0100000 : 7'b0000000), bus.rs2_i, bus.rs1_i,
                            bus.alu_i[2:0], bus.rd_i, 7'b0110011};
            end
            OP_ADDI: begin
                enc_word = {bus.imm_i[11:0], bus.rs1_i, bus.alu_i[2:0], bus.rd_i, 7'b0010011};
                enc_bad  = !imm12_ok;
            end
            OP_LW: begin
                enc_word = {bus.imm_i[11:0], bus.rs1_i, 3'b010, bus.rd_i, 7'b0000011};
                enc_bad  = !imm12_ok;
            end
            OP_SW: begin
                enc_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, 3'b010, bus.imm_i[4:0], 7'b0100011};
                enc_bad  = !imm12_ok;
            end
            OP_BEQ: begin
                enc_word = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, 3'b000,
                            bus.imm_i[4:1], bus.imm_i[11], 7'b1100011};
                enc_bad  = !imm13_ok || bus.imm_i[0];
            end
            OP_JAL: begin
                enc_word = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11], bus.imm_i[19:12],
                            bus.rd_i, 7'b1101111};
                enc_bad  = bus.imm_i[0];
            end
            OP_JALR: begin
                enc_word = {bus.imm_i[11:0], bus.rs1_i, 3'b000, bus.rd_i, 7'b1100111};
                enc_bad  = !imm12_ok;
            end
            default: begin
                enc_bad = 1'b1;
            end
        endcase
    end

    assign accept = bus.req_valid_i && bus.req_ready_o;
    assign push   = accept && !enc_bad;
    assign pop    = bus.imem_we_o && bus.imem_ready_i;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        err_d    = accept && enc_bad;

        if (push) begin
            fifo_d[wr_ptr_q] = enc_word;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            addr_d   = addr_q + ADDR_W'(32'd4);
            if (wcnt_q != '1) begin
                wcnt_d = wcnt_q + 16'd1;
            end
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= BASE_ADDR;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready_o = (cnt_q != 2'd2);
    assign bus.imem_we_o   = (cnt_q != 2'd0);
    assign bus.imem_addr_o = addr_q;
    assign bus.imem_data_o = bus.imem_we_o ? fifo_q[rd_ptr_q] : '0;
    assign err_o           = err_q;
    assign word_cnt_o      = wcnt_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction-word producer for the single-cycle RISC-V datapath. Accepts symbolic instruction requests through a valid/ready handshake and assembles each into a 32-bit RV32I word. It buffers the words in a 2-entry FIFO and writes them sequentially into instruction memory starting at a base address. The block covers exactly the opcode set that the main control decoder recognises (R-type, addi, lw, sw, beq, jal, jalr), so every word it emits decodes to a defined control vector.

## Interface
- BASE_ADDR, 32'h0000_0000, first instruction-memory byte address written after reset
- ADDR_W, 32, width of the address counter; wraps modulo 2^ADDR_W
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request this cycle
- op_i  in  3  0=R-type, 1=addi (I-ALU), 2=lw, 3=sw, 4=beq, 5=jal, 6=jalr, 7=illegal
- alu_i  in  4  {funct7[5], funct3}; used by op 0; op 1 uses alu_i[2:0] only
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- imm_i  in  21  signed byte immediate, sign-extended interpretation
- imem_we_o  out  1  write request to instruction memory (= FIFO non-empty)
- imem_addr_o  out  ADDR_W  byte address of the current write
- imem_data_o  out  32  encoded word at FIFO head
- imem_ready_i  in  1  memory accepts the write this cycle
- err_o  out  1  one-cycle pulse: the accepted request was rejected
- word_cnt_o  out  16  words written since reset, saturating at 16'hFFFF

## Operation
- Handshake: a request is accepted on a rising edge with req_valid_i && req_ready_o. req_ready_o = (fifo_count < 2), purely registered state, with no combinational path from imem_ready_i.
- Encode is combinational from the request inputs. The word is pushed into the FIFO on the accept edge.
  - op 0: {alu_i[3]?7'b0100000:7'b0, rs2, rs1, alu_i[2:0], rd, 7'b0110011}
  - op 1: {imm[11:0], rs1, alu_i[2:0], rd, 7'b0010011}
  - op 2: {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
  - op 3: {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}
  - op 4: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}
  - op 5: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}
  - op 6: {imm[12'], rs1, 3'b000, rd, 7'b1100111}, where imm[12'] denotes imm[11:0]
- Rejection. Any of the following is accepted (handshake completes) but not pushed; err_o pulses the next cycle:
  - op 7
  - ops 1/2/3/6 with imm outside −2048..2047
  - op 4 with imm outside −4096..4094 or imm[0]=1
  - op 5 with imm[0]=1 (the 21-bit range is implicit)
- Fields unused by a format are ignored and do not affect the word.
- Memory side: a write completes on an edge with imem_we_o && imem_ready_i. On completion the FIFO pops, imem_addr_o += 4 (mod 2^ADDR_W), and word_cnt_o increments unless saturated.
- FIFO behaviour:
  - Push and pop in the same edge leave fifo_count unchanged.
  - Push at count 2 cannot occur because ready is low.
  - Pop at count 0 cannot occur because we is low.
  - Order is strictly first in, first out.

## Timing
- Reset values:
  - req_ready_o=1
  - imem_we_o=0
  - imem_addr_o=BASE_ADDR
  - imem_data_o=0
  - err_o=0
  - word_cnt_o=0
  - FIFO empty
- Latency: a request accepted at edge N gives imem_we_o=1 with that word from cycle N+1. With imem_ready_i held high, the write completes at edge N+1.
- Throughput: one word per cycle sustained while imem_ready_i=1.
- Back-pressure: with imem_ready_i=0, at most 2 words are held and req_ready_o falls in the cycle after the second push. It rises again in the cycle after the first completed write.
- imem_data_o and imem_addr_o stay stable while imem_we_o=1 and imem_ready_i=0.
- err_o is high for exactly one cycle per rejected request. Back-to-back rejections give back-to-back pulses.
- Address wrap: with ADDR_W=8, a write at 8'hFC leaves the address at 8'h00 after completion.
- Reset asserted mid-operation, at any edge: the FIFO is discarded, the address returns to BASE_ADDR, the counter clears, and no write completes on that edge.

## Test plan
- Encode with imem_ready_i=1, writing at BASE_ADDR, +4, +8, +12, +16, +20 respectively:
  - add x3,x1,x2 (op0, alu 0) -> 0x002081B3
  - addi x5,x0,-1 -> 0xFFF00293
  - lw x4,4(x3) -> 0x0041A203
  - sw x2,8(x1) -> 0x0020A423
  - beq x1,x2,-8 -> 0xFE208CE3
  - jal x1,16 -> 0x010000EF
- Back-pressure: with imem_ready_i=0, offer 3 requests back-to-back. Only 2 are accepted and req_ready_o=0. Then raise imem_ready_i: writes occur in order, and the third request is accepted one cycle after the first write completes.
- Rejection: beq with imm=3, addi with imm=2048, and op 7 each give one err_o pulse, no imem_we_o, and no change to address or count. The following valid request still writes at the unchanged address.
- Wrap and saturation: with ADDR_W=8 and BASE_ADDR=8'hF8, 3 writes land at F8, FC, 00. With the counter forced near the limit, word_cnt_o holds at 16'hFFFF.
- Reset mid-stream: with 2 words buffered and imem_ready_i=0, assert rst_i for 1 cycle. Outputs return to their reset values, and a subsequent request writes at BASE_ADDR with word_cnt_o counting from 1.
